// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM states, the PC step and the default reset address.
package inst_fetch_pkg;

  typedef enum logic {
    WAIT = 1'b0,
    HOLD = 1'b1
  } fetch_state_t;

  localparam logic [31:0] WORD_STEP        = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Four bits cover every legal WAIT_CYCLES value (1..15).
  localparam int TIMER_W = 4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/inst_fetch_timer.sv
// Wait-state counter for the fetch unit: counts up from zero while not
// cleared and flags the last wait cycle so the FSM can sample im_d.
module fetch_timer
  import inst_fetch_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic done
);

  localparam logic [TIMER_W-1:0] LAST_COUNT = TIMER_W'(WAIT_CYCLES - 1);

  logic [TIMER_W-1:0] count_reg;
  logic [TIMER_W-1:0] count_next;

  always_comb begin
    count_next = count_reg + 1'b1;
    if (clear) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  assign done = (count_reg == LAST_COUNT);

endmodule

// File: rtl/inst_fetch.sv
// Single-outstanding instruction fetch: holds im_a for WAIT_CYCLES, captures
// im_d, then presents it with a valid/ready handshake; redirects win always.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] im_a,
  input  logic [31:0] im_d,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  fetch_state_t state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         valid_reg, valid_next;
  logic [31:0]  instr_reg, instr_next;
  logic [31:0]  instr_pc_reg, instr_pc_next;
  logic         timer_clear;
  logic         timer_done;

  fetch_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(timer_clear),
    .done (timer_done)
  );

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    valid_next    = valid_reg;
    instr_next    = instr_reg;
    instr_pc_next = instr_pc_reg;
    timer_clear   = 1'b0;

    if (redirect_valid) begin
      // A redirect also completes any handshake happening this cycle;
      // the new target simply replaces the sequential pc+4.
      pc_next     = word_align(redirect_pc);
      valid_next  = 1'b0;
      state_next  = WAIT;
      timer_clear = 1'b1;
    end else begin
      case (state_reg)
        WAIT: begin
          if (timer_done) begin
            instr_next    = im_d;
            instr_pc_next = pc_reg;
            valid_next    = 1'b1;
            state_next    = HOLD;
            timer_clear   = 1'b1;
          end
        end
        HOLD: begin
          // Keep the timer parked at zero so the next WAIT starts fresh.
          timer_clear = 1'b1;
          if (instr_ready) begin
            pc_next    = pc_reg + WORD_STEP;
            valid_next = 1'b0;
            state_next = WAIT;
          end
        end
        default: begin
          state_next  = WAIT;
          valid_next  = 1'b0;
          timer_clear = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= WAIT;
      pc_reg       <= word_align(RESET_PC);
      valid_reg    <= 1'b0;
      instr_reg    <= '0;
      instr_pc_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      valid_reg    <= valid_next;
      instr_reg    <= instr_next;
      instr_pc_reg <= instr_pc_next;
    end
  end

  assign im_a        = pc_reg;
  assign instr_valid = valid_reg;
  assign instr       = instr_reg;
  assign instr_pc    = instr_pc_reg;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: reset-sequence vector table, directed
// corner-case sequences, and a randomized run against a timestamp model.
module tb_inst_fetch;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] im_a;
  logic [31:0] im_d;
  logic        rv;
  logic [31:0] rpc;
  logic        instr_valid;
  logic        rdy;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a >> 2) * 32'h9E37_79B1 + 32'h1357_9BDF;
  endfunction

  assign im_d = mem_word(im_a);

  inst_fetch #(
    .RESET_PC   (32'h0000_0000),
    .WAIT_CYCLES(W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .im_a          (im_a),
    .im_d          (im_d),
    .redirect_valid(rv),
    .redirect_pc   (rpc),
    .instr_valid   (instr_valid),
    .instr_ready   (rdy),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Leaves the bench at cycle 0: just after the last reset edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rv  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_ipc;
    logic [31:0] exp_ima;
  } vec_t;

  vec_t tbl [9];

  // Behavioural model state for the random run.
  logic [31:0] m_addr, m_ipc;
  logic        m_hold;
  int          m_ready_at;
  int          xfers;

  initial begin
    rst = 1'b1; rv = 1'b0; rpc = '0; rdy = 1'b0;

    tbl[0] = '{1'b1, 1'b0, 32'h0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h0, 32'h0};
    tbl[2] = '{1'b1, 1'b1, 32'h0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 32'h0, 32'h4};
    tbl[4] = '{1'b1, 1'b0, 32'h0, 32'h4};
    tbl[5] = '{1'b1, 1'b1, 32'h4, 32'h4};
    tbl[6] = '{1'b1, 1'b0, 32'h0, 32'h8};
    tbl[7] = '{1'b1, 1'b0, 32'h0, 32'h8};
    tbl[8] = '{1'b1, 1'b1, 32'h8, 32'h8};

    // Reset sequencing with instr_ready tied high.
    do_reset();
    check("rst_valid", {31'b0, instr_valid}, 32'h0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("tbl%0d_valid", i), {31'b0, instr_valid}, {31'b0, tbl[i].exp_valid});
      check($sformatf("tbl%0d_im_a", i), im_a, tbl[i].exp_ima);
      if (tbl[i].exp_valid) begin
        check($sformatf("tbl%0d_instr_pc", i), instr_pc, tbl[i].exp_ipc);
        check($sformatf("tbl%0d_instr", i), instr, mem_word(tbl[i].exp_ipc));
      end
      $display("cycle %0d: valid=%0b instr_pc=%h im_a=%h", i, instr_valid, instr_pc, im_a);
      rdy = tbl[i].rdy;
      step();
    end

    // Backpressure: five stalled cycles in HOLD at address 4.
    do_reset();
    rdy = 1'b1;
    step(); step(); step();
    rdy = 1'b0;
    step(); step();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", {31'b0, instr_valid}, 32'h1);
      check("bp_instr_pc", instr_pc, 32'h4);
      check("bp_instr", instr, mem_word(32'h4));
      check("bp_im_a", im_a, 32'h4);
      step();
    end
    rdy = 1'b1;
    step();
    check("bp_adv_im_a", im_a, 32'h8);
    check("bp_adv_valid", {31'b0, instr_valid}, 32'h0);
    $display("backpressure: released, im_a=%h", im_a);

    // Redirect one cycle after leaving HOLD discards the fetch of 4.
    do_reset();
    rdy = 1'b1;
    step(); step(); step();
    check("rw_pre_im_a", im_a, 32'h4);
    rv = 1'b1; rpc = 32'h0000_0103;
    step();
    rv = 1'b0;
    check("rw_im_a", im_a, 32'h100);
    check("rw_valid0", {31'b0, instr_valid}, 32'h0);
    step();
    check("rw_no_stale", {31'b0, instr_valid}, 32'h0);
    step();
    check("rw_valid", {31'b0, instr_valid}, 32'h1);
    check("rw_instr_pc", instr_pc, 32'h100);
    check("rw_instr", instr, mem_word(32'h100));
    $display("redirect in WAIT: instr_pc=%h", instr_pc);

    // Handshake and redirect together: one transfer, then target 0x40.
    xfers = 0;
    rv = 1'b1; rpc = 32'h40; rdy = 1'b1;
    if (instr_valid && rdy) xfers++;
    step();
    rv = 1'b0;
    check("sim_valid0", {31'b0, instr_valid}, 32'h0);
    check("sim_im_a", im_a, 32'h40);
    if (instr_valid && rdy) xfers++;
    step();
    if (instr_valid && rdy) xfers++;
    rdy = 1'b0;
    step();
    check("sim_xfers", xfers, 32'd1);
    check("sim_valid", {31'b0, instr_valid}, 32'h1);
    check("sim_instr_pc", instr_pc, 32'h40);
    $display("simultaneous handshake+redirect: xfers=%0d instr_pc=%h", xfers, instr_pc);

    // Wrap-around from the top word.
    rv = 1'b1; rpc = 32'hFFFF_FFFF;
    step();
    rv = 1'b0;
    check("wrap_align", im_a, 32'hFFFF_FFFC);
    step(); step();
    check("wrap_valid", {31'b0, instr_valid}, 32'h1);
    check("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    rdy = 1'b1;
    step();
    rdy = 1'b0;
    check("wrap_im_a", im_a, 32'h0);
    $display("wrap: im_a=%h", im_a);

    // Reset while holding an instruction from 0x200.
    rv = 1'b1; rpc = 32'h200;
    step();
    rv = 1'b0;
    step(); step();
    check("rh_pre_valid", {31'b0, instr_valid}, 32'h1);
    check("rh_pre_instr_pc", instr_pc, 32'h200);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rh_valid", {31'b0, instr_valid}, 32'h0);
    check("rh_im_a", im_a, 32'h0);
    check("rh_instr_pc", instr_pc, 32'h0);
    check("rh_instr", instr, 32'h0);
    step(); step();
    check("rh_refetch_valid", {31'b0, instr_valid}, 32'h1);
    check("rh_refetch_pc", instr_pc, 32'h0);
    check("rh_refetch_instr", instr, mem_word(32'h0));
    $display("reset in HOLD: refetch instr_pc=%h", instr_pc);

    // Random run: model tracks the fetch address and the cycle its word lands.
    do_reset();
    m_addr = 32'h0; m_hold = 1'b0; m_ipc = 32'h0; m_ready_at = W;
    for (int cyc = 0; cyc < 600; cyc++) begin
      check("rnd_valid", {31'b0, instr_valid}, {31'b0, m_hold});
      check("rnd_im_a", im_a, m_addr);
      if (m_hold) begin
        check("rnd_instr_pc", instr_pc, m_ipc);
        check("rnd_instr", instr, mem_word(m_ipc));
      end
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = $urandom;
      if (m_hold && rdy)
        $display("rnd cycle %0d: accept instr_pc=%h instr=%h redirect=%0b", cyc, instr_pc, instr, rv);
      if (rv) begin
        m_addr     = rpc & ~32'h3;
        m_hold     = 1'b0;
        m_ready_at = cyc + 1 + W;
      end else if (m_hold) begin
        if (rdy) begin
          m_addr     = m_addr + 32'd4;
          m_hold     = 1'b0;
          m_ready_at = cyc + 1 + W;
        end
      end else if (cyc + 1 == m_ready_at) begin
        m_hold = 1'b1;
        m_ipc  = m_addr;
      end
      step();
    end
    rv = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning the number of cycles im_a is held before im_d is sampled; the legal range is 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port im_a, output, 32 bits: byte address presented to the instruction memory.
REQ-006 SHALL have port im_d, input, 32 bits: instruction word returned by the instruction memory.
REQ-007 SHALL have port redirect_valid, input, 1 bit: load a new PC (branch/jump) this cycle.
REQ-008 SHALL have port redirect_pc, input, 32 bits: target byte address.
REQ-009 SHALL have port instr_valid, output, 1 bit: instr/instr_pc hold a fetched instruction.
REQ-010 SHALL have port instr_ready, input, 1 bit: consumer accepts the instruction this cycle.
REQ-011 SHALL have port instr, output, 32 bits: the fetched instruction word.
REQ-012 SHALL have port instr_pc, output, 32 bits: the byte address instr was fetched from.

Function
REQ-013 SHALL keep a 32-bit pc register and drive im_a directly from pc, with no combinational path from any input to im_a.
REQ-014 SHALL implement states WAIT and HOLD.
REQ-015 In WAIT, SHALL increment a counter each cycle; on the cycle the counter equals WAIT_CYCLES-1, SHALL capture im_d into instr and pc into instr_pc, set instr_valid=1, clear the counter, and enter HOLD.
REQ-016 In HOLD, SHALL keep instr, instr_pc and instr_valid stable while instr_ready=0.
REQ-017 In HOLD with instr_ready=1, SHALL set pc<=pc+4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0), instr_valid<=0, and enter WAIT.
REQ-018 SHALL give fetch latency of exactly WAIT_CYCLES cycles from the pc update to instr_valid rising, and sustained throughput of one instruction per WAIT_CYCLES+1 cycles with instr_ready tied high.
REQ-019 redirect_valid=1 SHALL take priority in any state: pc<=redirect_pc with bits[1:0] forced to 0, counter<=0, instr_valid<=0, state<=WAIT.
REQ-020 If redirect_valid, instr_valid and instr_ready are all 1 in the same cycle, SHALL count the handshake as a completed transfer and apply the redirect, not pc+4.
REQ-021 A redirect during WAIT SHALL discard the in-flight fetch; the old address SHALL never appear on instr_pc.
REQ-022 instr_ready SHALL be ignored while instr_valid=0.

Reset
REQ-023 On rst=1 at a clock edge, SHALL set pc=RESET_PC with bits[1:0] forced to 0, state=WAIT, counter=0, instr_valid=0, instr=0 and instr_pc=0; this SHALL override redirect_valid.
REQ-024 Reset asserted mid-WAIT or mid-HOLD SHALL abandon the fetch, and the first instruction after release SHALL come from RESET_PC.

Structure
REQ-025 The shared package SHALL hold the state enumeration {WAIT, HOLD}, the word-step constant 4, and the default RESET_PC.
REQ-026 The wait counter SHALL be one sub-module fetch_timer, with ports clk, rst, clear and done, and a width sized for WAIT_CYCLES up to 15.
REQ-027 The design SHALL be fully synchronous, with no delay statements.

Verification
REQ-028 The bench SHALL check reset sequencing: with WAIT_CYCLES=2, im_d returning mem[a>>2] and instr_ready=1, release rst at cycle 0 -> instr_valid at cycle 2 with instr_pc=0, then instr_pc=4 at cycle 5 and 8 at cycle 8.
REQ-029 The bench SHALL check backpressure: hold instr_ready=0 for 5 cycles while in HOLD -> instr and instr_pc stay unchanged and im_a stays 4; on the first instr_ready=1, pc advances to 8.
REQ-030 The bench SHALL check redirect in WAIT: redirect_pc=32'h0000_0103 one cycle after leaving HOLD -> im_a=32'h100 on the next edge, the next instr_pc=32'h100, and no instruction from the discarded address.
REQ-031 The bench SHALL check simultaneous handshake and redirect: instr_valid=1, instr_ready=1 and redirect_valid=1 with redirect_pc=32'h40 -> the transfer counts once and the next instr_pc=32'h40.
REQ-032 The bench SHALL check wrap-around: redirect to 32'hFFFF_FFFC and accept -> the next im_a=0.
REQ-033 The bench SHALL check reset in HOLD: assert rst with instr_valid=1 -> instr_valid=0 the next cycle and the following fetch comes from RESET_PC.
